// File: rtl/uart_param_xcvr.sv
// Parametrised full-duplex UART: valid/ready TX, 16x-oversampled RX with parity/framing flags.
// Optional internal loopback (tx -> rx, pin held idle) when UART_LOOPBACK_EN is defined.
module uart_param_xcvr #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  input  logic                 rx_in,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned DivRaw   = CLK_FREQ / (BAUD * 16);
  localparam int unsigned Div      = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned DivW     = (Div > 1) ? $clog2(Div) : 1;
  localparam logic        OddPar   = (PARITY == 2);
  localparam logic [3:0]  LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_param_xcvr: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_param_xcvr: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_param_xcvr: STOP_BITS must be 1 or 2");
  end

  // Shared oversampling tick
  logic [DivW-1:0] div_q;
  logic            os_tick;
  assign os_tick = (div_q == DivW'(Div - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= os_tick ? '0 : div_q + DivW'(1);
  end

  // ---------------- Transmitter ----------------
  // TxWait holds the line idle until the next tick so every start bit is tick-aligned.
  typedef enum logic [2:0] {TxIdle, TxWait, TxStart, TxData, TxParity, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_tick_q, tx_tick_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (os_tick && tx_state_q inside {TxStart, TxData, TxParity, TxStop}) begin
      tx_tick_d = tx_tick_q + 4'd1;
    end
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ OddPar;
          tx_state_d = TxWait;
        end
      end
      TxWait: begin
        if (os_tick) begin
          tx_tick_d  = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (os_tick && tx_tick_q == 4'd15) begin
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (os_tick && tx_tick_q == 4'd15) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LastData) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? TxParity : TxStop;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      TxParity: begin
        if (os_tick && tx_tick_q == 4'd15) tx_state_d = TxStop;
      end
      TxStop: begin
        if (os_tick && tx_tick_q == 4'd15) begin
          if (tx_bit_q == LastStop) begin
            tx_bit_d   = '0;
            tx_state_d = TxIdle;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state_q)
      TxStart:  tx_line = 1'b0;
      TxData:   tx_line = tx_shift_q[0];
      TxParity: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
    tx_ready = (tx_state_q == TxIdle);
    tx_busy  = (tx_state_q != TxIdle);
  end

  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : rx_in;
  assign tx_out = loopback ? 1'b1 : tx_line;
`else
  assign rx_src = rx_in;
  assign tx_out = tx_line;
`endif

  // ---------------- Receiver ----------------
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx_src;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (os_tick && rx_state_q != RxIdle) rx_tick_d = rx_tick_q + 4'd1;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_tick_d  = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        // Mid start bit: a high line here was only a glitch.
        if (os_tick && rx_tick_q == 4'd7) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (os_tick && rx_tick_q == 4'd15) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LastData) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      RxParity: begin
        if (os_tick && rx_tick_q == 4'd15) begin
          rx_par_d   = rx_s2_q;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (os_tick && rx_tick_q == 4'd15) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_perr_d  = (PARITY != 0) && (rx_par_q != ((^rx_shift_q) ^ OddPar));
          rx_ferr_d  = !rx_s2_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_busy       = (rx_state_q != RxIdle);
    rx_data       = rx_data_q;
    rx_valid      = rx_valid_q;
    rx_parity_err = rx_perr_q;
    rx_frame_err  = rx_ferr_q;
  end

endmodule

// File: tb/tb_uart_param_xcvr.sv
// Self-checking bench for uart_param_xcvr: 8N1 and 8E1 instances at 16 clocks/bit,
// plus a 9-bit/2-stop loopback instance when UART_LOOPBACK_EN is defined.
module tb_uart_param_xcvr;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  rx_exp_t sb_main[$];
  rx_exp_t sb_par[$];
  rx_exp_t sb_lb[$];
  logic    tx_exp_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  // 8N1 instance
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_out, tx_busy, rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, rx_perr, rx_ferr, rx_busy;
  // 8E1 instance (receive side only)
  logic [7:0] p_tx_data;
  logic       p_tx_valid, p_tx_ready, p_tx_out, p_tx_busy, p_rx_in;
  logic [7:0] p_rx_data;
  logic       p_rx_valid, p_rx_perr, p_rx_ferr, p_rx_busy;

`ifdef UART_LOOPBACK_EN
  logic       lb_off = 1'b0;
  logic       lb = 1'b1;
  logic [8:0] l_tx_data;
  logic       l_tx_valid, l_tx_ready, l_tx_out, l_tx_busy, l_rx_in;
  logic [8:0] l_rx_data;
  logic       l_rx_valid, l_rx_perr, l_rx_ferr, l_rx_busy;

  uart_param_xcvr #(
    .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)
  ) dut_l (
    .clock(clock), .reset(reset), .tx_data(l_tx_data), .tx_valid(l_tx_valid),
    .tx_ready(l_tx_ready), .tx_out(l_tx_out), .tx_busy(l_tx_busy), .rx_in(l_rx_in),
    .loopback(lb), .rx_data(l_rx_data), .rx_valid(l_rx_valid), .rx_parity_err(l_rx_perr),
    .rx_frame_err(l_rx_ferr), .rx_busy(l_rx_busy)
  );
`endif

  uart_param_xcvr #(
    .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_in),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_off),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_perr),
    .rx_frame_err(rx_ferr), .rx_busy(rx_busy)
  );

  uart_param_xcvr #(
    .CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
  ) dut_p (
    .clock(clock), .reset(reset), .tx_data(p_tx_data), .tx_valid(p_tx_valid),
    .tx_ready(p_tx_ready), .tx_out(p_tx_out), .tx_busy(p_tx_busy), .rx_in(p_rx_in),
`ifdef UART_LOOPBACK_EN
    .loopback(lb_off),
`endif
    .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_parity_err(p_rx_perr),
    .rx_frame_err(p_rx_ferr), .rx_busy(p_rx_busy)
  );

  // Drive a serial bit vector (LSB first) on the chosen rx line, 16 clocks per bit.
  task automatic drive_rx(input int which, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx_in = bits[i];
      else            p_rx_in = bits[i];
      repeat (16) @(negedge clock);
    end
    if (which == 0) rx_in = 1'b1;
    else            p_rx_in = 1'b1;
  endtask

  // Wait (bounded) for rx_valid and capture the delivered word; extra = valid on the next cycle.
  task automatic collect_rx(input int which, output bit got, output logic [8:0] d,
                            output logic pe, output logic fe, output logic extra);
    got = 1'b0; d = '0; pe = 1'b0; fe = 1'b0; extra = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      if (which == 0 && rx_valid) begin
        got = 1'b1; d = {1'b0, rx_data}; pe = rx_perr; fe = rx_ferr;
      end else if (which == 1 && p_rx_valid) begin
        got = 1'b1; d = {1'b0, p_rx_data}; pe = p_rx_perr; fe = p_rx_ferr;
      end
    end
    if (got) begin
      @(negedge clock);
      extra = (which == 0) ? rx_valid : p_rx_valid;
    end
  endtask

  task automatic test_reset;
    logic [7:0] got_v;
    logic [7:0] want_v;
    string      names[8];
    names = '{"tx_out", "tx_ready", "tx_busy", "rx_busy", "rx_valid", "rx_perr", "rx_ferr",
              "rx_data_nz"};
    reset = 1'b1;
    tx_data = '0; tx_valid = 1'b0; rx_in = 1'b1;
    p_tx_data = '0; p_tx_valid = 1'b0; p_rx_in = 1'b1;
`ifdef UART_LOOPBACK_EN
    l_tx_data = '0; l_tx_valid = 1'b0; l_rx_in = 1'b1;
`endif
    repeat (3) @(negedge clock);
    got_v  = {tx_out, tx_ready, tx_busy, rx_busy, rx_valid, rx_perr, rx_ferr, |rx_data};
    want_v = 8'b1100_0000;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_v[7-i] !== want_v[7-i]) begin
        n_bad++;
        $display("FAIL reset_%s: got %b want %b", names[i], got_v[7-i], want_v[7-i]);
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Send one word on the 8N1 instance and check every clock of the line waveform.
  task automatic test_tx_frame(input logic [7:0] d, input string tag);
    int   rdy_low;
    logic exp;
    @(negedge clock);
    tx_data = d; tx_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 16; k++) begin
        if (b == 0)      tx_exp_q.push_back(1'b0);
        else if (b == 9) tx_exp_q.push_back(1'b1);
        else             tx_exp_q.push_back(d[b-1]);
      end
    end
    @(negedge clock);
    // Keep offering a different word while busy: it must be ignored.
    tx_data = ~d;
    rdy_low = 0;
    if (!tx_ready) rdy_low++;
    n_cmp++;
    if (tx_busy !== 1'b1) begin
      n_bad++; $display("FAIL %s_busy_after_accept: got %b want 1", tag, tx_busy);
    end
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (i == 19) tx_valid = 1'b0;
      exp = tx_exp_q.pop_front();
      n_cmp++;
      if (tx_out !== exp) begin
        n_bad++; $display("FAIL %s_line[%0d]: got %b want %b", tag, i, tx_out, exp);
      end
      if (!tx_ready) rdy_low++;
    end
    for (int i = 0; i < 20 && !tx_ready; i++) begin
      @(negedge clock);
      if (!tx_ready) rdy_low++;
    end
    n_cmp++;
    if (rdy_low < 159 || rdy_low > 161) begin
      n_bad++; $display("FAIL %s_ready_low_clocks: got %0d want 160+-1", tag, rdy_low);
    end
    n_cmp++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL %s_idle_after: got out=%b busy=%b want out=1 busy=0", tag,
                        tx_out, tx_busy);
    end
  endtask

  task automatic test_parity;
    logic [7:0] pd[3]  = '{8'hA5, 8'hA5, 8'h07};
    logic       pb[3]  = '{1'b0, 1'b1, 1'b1};
    logic       pe_w[3] = '{1'b0, 1'b1, 1'b0};
    rx_exp_t    e;
    bit         got;
    logic [8:0] d;
    logic       pe, fe, extra;
    for (int t = 0; t < 3; t++) begin
      sb_par.push_back('{data: {1'b0, pd[t]}, perr: pe_w[t], ferr: 1'b0});
      fork
        drive_rx(1, {21'd0, 1'b1, pb[t], pd[t], 1'b0}, 11);
        collect_rx(1, got, d, pe, fe, extra);
      join
      e = sb_par.pop_front();
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL parity[%0d]_valid: got none want one rx_valid", t);
      end
      n_cmp++;
      if (d !== e.data || pe !== e.perr || fe !== e.ferr) begin
        n_bad++;
        $display("FAIL parity[%0d]_word: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", t, d,
                 pe, fe, e.data, e.perr, e.ferr);
      end
      n_cmp++;
      if (extra !== 1'b0) begin
        n_bad++; $display("FAIL parity[%0d]_pulse_width: got valid=%b next cycle want 0", t, extra);
      end
      repeat (8) @(negedge clock);
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] fd[2]  = '{8'h3C, 8'h00};
    logic       stp[2] = '{1'b0, 1'b1};
    rx_exp_t    e;
    bit         got;
    logic [8:0] d;
    logic       pe, fe, extra;
    for (int t = 0; t < 2; t++) begin
      sb_main.push_back('{data: {1'b0, fd[t]}, perr: 1'b0, ferr: ~stp[t]});
      fork
        drive_rx(0, {22'd0, stp[t], fd[t], 1'b0}, 10);
        collect_rx(0, got, d, pe, fe, extra);
      join
      e = sb_main.pop_front();
      n_cmp++;
      if (!got || d !== e.data || pe !== e.perr || fe !== e.ferr || extra !== 1'b0) begin
        n_bad++;
        $display("FAIL frame[%0d]: got v=%b d=%h pe=%b fe=%b x=%b want v=1 d=%h pe=%b fe=%b x=0",
                 t, got, d, pe, fe, extra, e.data, e.perr, e.ferr);
      end
      repeat (20) @(negedge clock);
      n_cmp++;
      if (rx_ferr !== e.ferr) begin
        n_bad++; $display("FAIL frame[%0d]_flag_hold: got %b want %b", t, rx_ferr, e.ferr);
      end
    end
  endtask

  task automatic test_glitch;
    bit seen_busy = 1'b0;
    int pulses = 0;
    @(negedge clock);
    rx_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 4) rx_in = 1'b1;
      if (rx_busy) seen_busy = 1'b1;
      if (rx_valid) pulses++;
      if (i == 13) begin
        n_cmp++;
        if (rx_busy !== 1'b0) begin
          n_bad++; $display("FAIL glitch_busy_cleared: got %b want 0", rx_busy);
        end
      end
    end
    n_cmp++;
    if (!seen_busy) begin
      n_bad++; $display("FAIL glitch_start_seen: got rx_busy never high want high");
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("FAIL glitch_no_valid: got %0d pulses want 0", pulses);
    end
  endtask

  // Two frames with no idle gap: the second start edge follows the first stop bit directly.
  task automatic test_back_to_back;
    logic [7:0] bd[2] = '{8'h81, 8'h7E};
    rx_exp_t    e;
    bit         got;
    logic [8:0] d;
    logic       pe, fe, extra;
    for (int t = 0; t < 2; t++) sb_main.push_back('{data: {1'b0, bd[t]}, perr: 1'b0, ferr: 1'b0});
    fork
      drive_rx(0, {12'd0, 1'b1, bd[1], 1'b0, 1'b1, bd[0], 1'b0}, 20);
      for (int t = 0; t < 2; t++) begin
        collect_rx(0, got, d, pe, fe, extra);
        e = sb_main.pop_front();
        n_cmp++;
        if (!got || d !== e.data || pe !== e.perr || fe !== e.ferr) begin
          n_bad++;
          $display("FAIL b2b[%0d]: got v=%b d=%h pe=%b fe=%b want v=1 d=%h pe=%b fe=%b", t, got,
                   d, pe, fe, e.data, e.perr, e.ferr);
        end
      end
    join
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset_mid_tx;
    @(negedge clock);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (72) @(negedge clock);
    n_cmp++;
    if (tx_busy !== 1'b1) begin
      n_bad++; $display("FAIL midtx_busy_before_reset: got %b want 1", tx_busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midtx_async_reset: got out=%b ready=%b busy=%b want 1 1 0", tx_out,
               tx_ready, tx_busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_tx_frame(8'h5A, "post_reset");
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    rx_exp_t    e;
    bit         got = 1'b0;
    int         hi_viol = 0;
    logic [8:0] d = '0;
    logic       pe = 1'b0, fe = 1'b0;
    sb_lb.push_back('{data: 9'h1A5, perr: 1'b0, ferr: 1'b0});
    @(negedge clock);
    l_tx_data = 9'h1A5; l_tx_valid = 1'b1;
    @(negedge clock);
    l_tx_valid = 1'b0;
    for (int i = 0; i < 600 && (!got || l_tx_busy); i++) begin
      @(negedge clock);
      if (l_tx_out !== 1'b1) hi_viol++;
      if (l_rx_valid) begin
        got = 1'b1; d = l_rx_data; pe = l_rx_perr; fe = l_rx_ferr;
      end
    end
    e = sb_lb.pop_front();
    n_cmp++;
    if (!got || d !== e.data || pe !== e.perr || fe !== e.ferr) begin
      n_bad++;
      $display("FAIL loopback_word: got v=%b d=%h pe=%b fe=%b want v=1 d=%h pe=%b fe=%b", got, d,
               pe, fe, e.data, e.perr, e.ferr);
    end
    n_cmp++;
    if (hi_viol != 0) begin
      n_bad++; $display("FAIL loopback_pin_idle: got %0d low clocks want 0", hi_viol);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame(8'hBE, "tx_be");
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_tx();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_param_xcvr.md
Name: uart_param_xcvr

Overview:
Parametrised full-duplex UART transceiver. It is the successor to the fixed 8N1 uart block.
- Generalised data width, parity mode and stop-bit count.
- Valid/ready transmit handshake.
- 16x-oversampled receiver with glitch rejection, parity-error and framing-error flags.
- Sits between a byte-stream client and the board serial pins, on the single system clock domain.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2; TX emits this many; RX checks only the first

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
tx_data  in  DATA_BITS  payload to send, LSB first
tx_valid  in  1  tx_data offered
tx_ready  out  1  high when the transmitter accepts a word this cycle
tx_out  out  1  serial line out, idle high
tx_busy  out  1  frame in progress
rx_in  in  1  serial line in, asynchronous
rx_data  out  DATA_BITS  last received payload
rx_valid  out  1  one-cycle pulse when rx_data is updated
rx_parity_err  out  1  parity mismatch on the frame flagged by rx_valid
rx_frame_err  out  1  stop bit sampled low on the frame flagged by rx_valid
rx_busy  out  1  receive frame in progress

Behaviour:
- Reset values:
  - tx_out = 1, tx_ready = 1.
  - tx_busy, rx_busy, rx_valid, rx_parity_err, rx_frame_err = 0.
  - rx_data = 0.
  - All counters = 0.
- Tick generator: DIV = CLK_FREQ/(BAUD*16), integer floor, minimum 1. A free-running counter produces a 1-cycle os_tick every DIV clocks. TX and RX share it.
- TX handshake:
  - A word is accepted when tx_valid && tx_ready at a rising edge; tx_data is latched that cycle.
  - tx_ready = (tx_state == IDLE). It drops the cycle after acceptance.
- TX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when PARITY = 0.
  - START begins at the next os_tick after acceptance.
  - Each bit lasts 16 os_ticks.
  - DATA shifts LSB first, DATA_BITS bits.
  - Parity bit: even = XOR of the data bits; odd = its inverse.
  - STOP drives 1 for STOP_BITS*16 ticks, then returns to IDLE; tx_ready rises the next cycle.
  - tx_busy = !IDLE.
- RX input: rx_in passes through a 2-flop synchroniser before any use.
- RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - Leave IDLE on a synchronised 1->0 edge; reset the tick count.
  - START: at tick 8, if the line is high, treat it as a glitch and return to IDLE with no flags. Otherwise zero the tick count.
  - Each subsequent bit is sampled at its 16th tick, i.e. mid-bit.
  - DATA shifts in LSB first.
  - PARITY: compare against the computed parity.
  - STOP: sample once.
  - At the stop sample:
    - load rx_data;
    - set rx_parity_err and rx_frame_err for this frame;
    - pulse rx_valid for exactly 1 clock;
    - return to IDLE.
- Error flags hold their value until the next rx_valid.
- A frame with errors still delivers data and rx_valid.
- Back-to-back frames: RX re-arms in IDLE immediately after the stop sample, so a start edge arriving within the second half of the stop bit is caught.
- rx_busy = !IDLE.
- Simultaneous events: TX and RX are fully independent; an os_tick coinciding with tx acceptance does not start START early (START waits for the next os_tick).
- tx_valid held high while busy: ignored until tx_ready; no queueing.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronous), the FSMs go to IDLE, and no rx_valid is issued.
- Illegal parameters (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS not 1 or 2) are flagged by an elaboration-time error.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback = 1:
  - the RX synchroniser input is tx_out instead of rx_in;
  - tx_out is forced high on the pin;
  - the internal loop still carries the frame.
  - Switching loopback mid-frame is undefined; the bench switches only when both FSMs are idle.
- Undefined: no loopback port; RX always samples rx_in.

Test Plan:
1. CLK_FREQ=1600000, BAUD=100000 (DIV=1, 16 clocks/bit), 8N1, send 8'hBE -> tx_out low 16 clocks, then 0,1,1,1,1,1,0,1 for 16 clocks each, then high; tx_ready low for 160 clocks ±1 tick.
2. Same clock and baud, PARITY=1, drive rx_in with frame 8'hA5 carrying a correct parity bit 0 -> one rx_valid pulse, rx_data=8'hA5, rx_parity_err=0. Repeat with parity bit 1 -> rx_parity_err=1.
3. rx_in frame 8'h3C with stop bit driven 0 -> rx_valid, rx_data=8'h3C, rx_frame_err=1. Next good frame 8'h00 -> both flags 0.
4. rx_in low pulse of 5 clocks -> no rx_valid; rx_busy returns 0 by clock 10.
5. Assert reset for 3 clocks mid-TX of 8'hFF (during data bit 3) -> tx_out=1, tx_ready=1 immediately. A new word after reset is sent as a complete frame.
6. With UART_LOOPBACK_EN, loopback=1, DATA_BITS=9, STOP_BITS=2, send 9'h1A5 -> rx_data=9'h1A5, no errors; tx_out pin stays 1 throughout.
